cpu_bus_decoder: RTL and testbench

Address decoder and read-data return stage directly downstream of the RV32 CPU wrapper. Takes the wrapper's strobed address, write data, write pulse and byte enables, steers each access to one of `NumSlots` peripheral slots by base/mask match, and registers the selected slot's read data so it is valid in the cycle the CPU samples it. Unmapped accesses return a fixed pattern. With the optional feature compiled in, they are also counted and logged.

---
 rtl/cpu_bus_pkg.sv | 12 +
 rtl/cpu_bus_addr_match.sv | 13 +
 rtl/cpu_bus_decoder.sv | 136 +++++++++++++
 tb/tb_cpu_bus_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared bus widths, data type and the default read pattern returned for unmapped CPU accesses.
package cpu_bus_pkg;

  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_BE_W   = 4;

  typedef logic [BUS_DATA_W-1:0] bus_data_t;
  typedef logic [BUS_BE_W-1:0]   bus_be_t;

  localparam bus_data_t DEFAULT_UNMAPPED = 32'hDEAD_BEEF;

endpackage : cpu_bus_pkg

// File: rtl/cpu_bus_addr_match.sv
// Single-slot address comparator: hit when the masked address equals the masked slot base.
module cpu_bus_addr_match #(
  parameter int unsigned              address_width = 32,
  parameter logic [address_width-1:0] Base          = '0,
  parameter logic [address_width-1:0] Mask          = '1
) (
  input  logic [address_width-1:0] address_i,
  output logic                     hit_o
);

  assign hit_o = ((address_i & Mask) == (Base & Mask));

endmodule : cpu_bus_addr_match

// File: rtl/cpu_bus_decoder.sv
// CPU address decoder with registered read-data return; unmapped-access logging is
// compiled in with the CPU_BUS_DECODER_ERR_LOG_EN macro.
module cpu_bus_decoder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned                       address_width = 32,
  parameter int unsigned                       NumSlots      = 4,
  parameter logic [NumSlots*address_width-1:0] SlotBase      = {NumSlots{32'h0000_0000}},
  parameter logic [NumSlots*address_width-1:0] SlotMask      = {NumSlots{32'hFFFF_F000}},
  parameter bus_data_t                         UnmappedData  = DEFAULT_UNMAPPED
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic [address_width-1:0]       cpu_address_i,
  input  logic [BUS_DATA_W-1:0]          cpu_data_i,
  input  logic                           cpu_we_i,
  input  logic [BUS_BE_W-1:0]            cpu_we_ram_i,
  output logic [BUS_DATA_W-1:0]          cpu_data_o,
  output logic [NumSlots-1:0]            slot_sel_o,
  output logic [address_width-1:0]       slot_addr_o,
  output logic [BUS_DATA_W-1:0]          slot_wdata_o,
  output logic [NumSlots-1:0]            slot_we_o,
  output logic [BUS_BE_W-1:0]            slot_be_o,
  input  logic [NumSlots*BUS_DATA_W-1:0] slot_rdata_i,
  output logic [15:0]                    err_count_o,
  output logic [address_width-1:0]       err_addr_o
);

  logic [NumSlots-1:0]      hit_s;
  logic [NumSlots-1:0]      sel_oh_s;
  logic                     hit_any_s;
  logic [address_width-1:0] mask_sel_s;
  bus_data_t                rdata_sel_s;
  bus_data_t                cpu_data_d;
  bus_data_t                cpu_data_q;

  for (genvar k = 0; k < NumSlots; k++) begin : g_match
    cpu_bus_addr_match #(
      .address_width (address_width),
      .Base          (SlotBase[k*address_width +: address_width]),
      .Mask          (SlotMask[k*address_width +: address_width])
    ) u_match (
      .address_i (cpu_address_i),
      .hit_o     (hit_s[k])
    );
  end

  // Priority select: the first (lowest-index) hitting slot owns the access.
  always_comb begin
    sel_oh_s    = '0;
    hit_any_s   = 1'b0;
    mask_sel_s  = '0;
    rdata_sel_s = '0;
    for (int k = 0; k < NumSlots; k++) begin
      if (hit_s[k] && !hit_any_s) begin
        sel_oh_s[k] = 1'b1;
        hit_any_s   = 1'b1;
        mask_sel_s  = SlotMask[k*address_width +: address_width];
        rdata_sel_s = slot_rdata_i[k*BUS_DATA_W +: BUS_DATA_W];
      end else begin
        sel_oh_s[k] = 1'b0;
      end
    end
  end

  assign slot_sel_o   = sel_oh_s;
  assign slot_addr_o  = hit_any_s ? (cpu_address_i & ~mask_sel_s) : '0;
  assign slot_wdata_o = cpu_data_i;
  assign slot_be_o    = cpu_we_ram_i;
  assign slot_we_o    = {NumSlots{cpu_we_i}} & sel_oh_s;

  // Read-data next value: selected slot data, or the fixed pattern when nothing decodes.
  always_comb begin
    if (hit_any_s) begin
      cpu_data_d = rdata_sel_s;
    end else begin
      cpu_data_d = UnmappedData;
    end
  end

  // Read-data register, sampled by the CPU in the cycle after the strobe.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cpu_data_q <= '0;
    end else begin
      cpu_data_q <= cpu_data_d;
    end
  end

  assign cpu_data_o = cpu_data_q;

`ifdef CPU_BUS_DECODER_ERR_LOG_EN
  logic                     acc_s;
  logic [15:0]              err_count_d;
  logic [15:0]              err_count_q;
  logic [address_width-1:0] err_addr_d;
  logic [address_width-1:0] err_addr_q;

  // Address 0 with no write is the wrapper's idle strobe, not a real access.
  assign acc_s = (cpu_address_i != '0) | cpu_we_i;

  // Unmapped-access log: saturating count plus the most recent offending address.
  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (acc_s && !hit_any_s) begin
      err_addr_d = cpu_address_i;
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      err_addr_d = err_addr_q;
    end
  end

  // Error log registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err_count_q <= 16'h0000;
      err_addr_q  <= '0;
    end else begin
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_count_o = err_count_q;
  assign err_addr_o  = err_addr_q;
`else
  assign err_count_o = 16'h0000;
  assign err_addr_o  = '0;
`endif

endmodule : cpu_bus_decoder

// File: tb/tb_cpu_bus_decoder.sv
// Self-checking bench for cpu_bus_decoder: directed vector table, back-to-back and
// async-reset sequences, then randomized accesses against a behavioural decode model.
module tb_cpu_bus_decoder;

  localparam int AW = 32;
  localparam int NS = 4;
  localparam logic [NS*AW-1:0] BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
  localparam logic [NS*AW-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_F800, 32'hFFFF_F000, 32'hFFFF_F000};

  logic            clk = 1'b0;
  logic            reset_ni;
  logic [AW-1:0]   cpu_address_i;
  logic [31:0]     cpu_data_i;
  logic            cpu_we_i;
  logic [3:0]      cpu_we_ram_i;
  logic [31:0]     cpu_data_o;
  logic [NS-1:0]   slot_sel_o;
  logic [AW-1:0]   slot_addr_o;
  logic [31:0]     slot_wdata_o;
  logic [NS-1:0]   slot_we_o;
  logic [3:0]      slot_be_o;
  logic [NS*32-1:0] slot_rdata_i;
  logic [15:0]     err_count_o;
  logic [AW-1:0]   err_addr_o;

  cpu_bus_decoder #(
    .address_width (AW),
    .NumSlots      (NS),
    .SlotBase      (BASE),
    .SlotMask      (MASK)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_ni),
    .cpu_address_i (cpu_address_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_we_i      (cpu_we_i),
    .cpu_we_ram_i  (cpu_we_ram_i),
    .cpu_data_o    (cpu_data_o),
    .slot_sel_o    (slot_sel_o),
    .slot_addr_o   (slot_addr_o),
    .slot_wdata_o  (slot_wdata_o),
    .slot_we_o     (slot_we_o),
    .slot_be_o     (slot_be_o),
    .slot_rdata_i  (slot_rdata_i),
    .err_count_o   (err_count_o),
    .err_addr_o    (err_addr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference memory map and per-slot read data.
  logic [31:0] m_base [NS];
  logic [31:0] m_mask [NS];
  logic [31:0] m_rdata[NS];
  logic [15:0] m_err_cnt;
  logic [31:0] m_err_addr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  exp_sel;
    logic [31:0] exp_saddr;
    logic [3:0]  exp_swe;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int ref_slot(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if ((a & m_mask[k]) == (m_base[k] & m_mask[k])) return k;
    end
    return -1;
  endfunction

  // One access: drive at negedge, check combinational outputs, then registered ones after the edge.
  task automatic run_cycle(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [3:0] be, input logic [3:0] exp_sel,
                           input logic [31:0] exp_saddr, input logic [3:0] exp_swe,
                           input logic [31:0] exp_data);
    @(negedge clk);
    cpu_address_i = addr;
    cpu_data_i    = wdata;
    cpu_we_i      = we;
    cpu_we_ram_i  = be;
    slot_rdata_i  = {m_rdata[3], m_rdata[2], m_rdata[1], m_rdata[0]};
    #1;
    check({tag, "_sel"},   {28'd0, slot_sel_o}, {28'd0, exp_sel});
    check({tag, "_saddr"}, slot_addr_o, exp_saddr);
    check({tag, "_swe"},   {28'd0, slot_we_o}, {28'd0, exp_swe});
    check({tag, "_be"},    {28'd0, slot_be_o}, {28'd0, be});
    check({tag, "_wdata"}, slot_wdata_o, wdata);
    if (((addr != 32'd0) || we) && (exp_sel == 4'd0)) begin
      m_err_addr = addr;
      if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    check({tag, "_rdata"}, cpu_data_o, exp_data);
`ifdef CPU_BUS_DECODER_ERR_LOG_EN
    check({tag, "_errcnt"},  {16'd0, err_count_o}, {16'd0, m_err_cnt});
    check({tag, "_erraddr"}, err_addr_o, m_err_addr);
`else
    check({tag, "_errcnt"},  {16'd0, err_count_o}, 32'd0);
    check({tag, "_erraddr"}, err_addr_o, 32'd0);
`endif
  endtask

  // Same access with every expectation derived from the reference map.
  task automatic run_model(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [3:0] be);
    int          idx;
    logic [3:0]  sel;
    logic [31:0] saddr;
    logic [31:0] data;
    idx   = ref_slot(addr);
    sel   = (idx >= 0) ? 4'(1 << idx) : 4'd0;
    saddr = (idx >= 0) ? (addr & ~m_mask[idx]) : 32'd0;
    data  = (idx >= 0) ? m_rdata[idx] : 32'hDEAD_BEEF;
    run_cycle(tag, addr, wdata, we, be, sel, saddr, we ? sel : 4'd0, data);
  endtask

  initial begin
    m_base[0] = 32'h0000_2000; m_mask[0] = 32'hFFFF_F000;
    m_base[1] = 32'h0000_1000; m_mask[1] = 32'hFFFF_F000;
    m_base[2] = 32'h0000_2000; m_mask[2] = 32'hFFFF_F800;
    m_base[3] = 32'h0000_3000; m_mask[3] = 32'hFFFF_F000;
    m_rdata[0] = 32'hAAAA_0000;
    m_rdata[1] = 32'h1234_5678;
    m_rdata[2] = 32'hBBBB_2222;
    m_rdata[3] = 32'hCCCC_3333;
    m_err_cnt  = 16'd0;
    m_err_addr = 32'd0;

    //            addr          wdata         we    be       sel      saddr         swe      data
    vecs[0] = '{32'h0000_1004, 32'h0000_0000, 1'b0, 4'b0000, 4'b0010, 32'h0000_0004, 4'b0000, 32'h1234_5678};
    vecs[1] = '{32'h0000_1008, 32'hA5A5_A5A5, 1'b1, 4'b0011, 4'b0010, 32'h0000_0008, 4'b0010, 32'h1234_5678};
    vecs[2] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_2000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0001, 32'h0000_0000, 4'b0000, 32'hAAAA_0000};
    vecs[4] = '{32'h0000_3ABC, 32'h0000_0000, 1'b0, 4'b0000, 4'b1000, 32'h0000_0ABC, 4'b0000, 32'hCCCC_3333};
    vecs[5] = '{32'h9000_0004, 32'h1111_2222, 1'b1, 4'b1111, 4'b0000, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF};
    vecs[7] = '{32'h0000_0000, 32'h5555_0000, 1'b1, 4'b1100, 4'b0000, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF};
    vecs[8] = '{32'h0000_27FC, 32'h0000_0000, 1'b0, 4'b0000, 4'b0001, 32'h0000_07FC, 4'b0000, 32'hAAAA_0000};

    reset_ni      = 1'b0;
    cpu_address_i = 32'd0;
    cpu_data_i    = 32'd0;
    cpu_we_i      = 1'b0;
    cpu_we_ram_i  = 4'd0;
    slot_rdata_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata",   cpu_data_o, 32'd0);
    check("reset_errcnt",  {16'd0, err_count_o}, 32'd0);
    check("reset_erraddr", err_addr_o, 32'd0);
    @(negedge clk);
    reset_ni = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_cycle($sformatf("tbl%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].be,
                vecs[i].exp_sel, vecs[i].exp_saddr, vecs[i].exp_swe, vecs[i].exp_data);
    end

    // Back-to-back reads with no idle cycle in between.
    run_cycle("b2b_a", 32'h0000_1000, 32'd0, 1'b0, 4'd0, 4'b0010, 32'h0000_0000, 4'd0, 32'h1234_5678);
    run_cycle("b2b_b", 32'h0000_3000, 32'd0, 1'b0, 4'd0, 4'b1000, 32'h0000_0000, 4'd0, 32'hCCCC_3333);

    // Randomized accesses checked against the reference map.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      for (int k = 0; k < NS; k++) m_rdata[k] = $urandom;
      case ($urandom_range(0, 5))
        0:       a = 32'h0000_1000 | 32'($urandom_range(0, 4095));
        1:       a = 32'h0000_2000 | 32'($urandom_range(0, 4095));
        2:       a = 32'h0000_3000 | 32'($urandom_range(0, 4095));
        3:       a = 32'h0000_0000;
        4:       a = 32'h0000_4000 | 32'($urandom_range(0, 4095));
        default: a = $urandom;
      endcase
      run_model($sformatf("rnd%0d", n), a, $urandom, ($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15)));
    end

    // Give the read register a known non-zero value, then assert reset mid-access.
    m_rdata[1] = 32'h0F0F_1234;
    run_model("pre_rst", 32'h0000_1010, 32'd0, 1'b0, 4'd0);
    run_model("pre_rst_err", 32'h7000_0000, 32'd0, 1'b1, 4'd0);
    @(negedge clk);
    cpu_address_i = 32'h0000_1004;
    cpu_we_i      = 1'b0;
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_rst_rdata",   cpu_data_o, 32'd0);
    check("async_rst_errcnt",  {16'd0, err_count_o}, 32'd0);
    check("async_rst_erraddr", err_addr_o, 32'd0);
    m_err_cnt  = 16'd0;
    m_err_addr = 32'd0;
    @(posedge clk);
    #1;
    check("rst_hold_rdata", cpu_data_o, 32'd0);
    @(negedge clk);
    reset_ni = 1'b1;
    m_rdata[3] = 32'h3141_5926;
    run_model("post_rst", 32'h0000_3004, 32'd0, 1'b0, 4'd0);
    run_model("post_rst_unm", 32'h0000_5000, 32'd0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_cpu_bus_decoder
